rr_latency_scheduler: RTL and testbench

- Shares a single latency counter among NUM_REQ requesters. Each requester asks for a fixed number of clock periods of occupancy, for example a functional-unit latency in the simulator pipeline.
- Arbitrates round-robin and counts the granted latency.
- Reports completion with a valid/ready done handshake tagged with the requester ID.
- Sits between issue logic and the shared multi-cycle resource. Only one job is in flight at a time.

---
 rtl/rr_latency_scheduler.sv | 91 +++++++++
 tb/tb_rr_latency_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_latency_scheduler.sv
// Round-robin scheduler that shares one latency counter among NUM_REQ requesters.
// One job is in flight at a time; completion is reported with a valid/ready handshake tagged by requester ID.
module rr_latency_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_vld,
  input  logic [NUM_REQ*CNT_W-1:0] req_cycles,
  output logic [NUM_REQ-1:0]       req_rdy,
  output logic                     done_vld,
  output logic [ID_W-1:0]          done_id,
  input  logic                     done_rdy,
  output logic                     busy
);

  typedef enum logic {IDLE, COUNT} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic              acc_ok;
  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   scan_idx;
  logic [CNT_W-1:0]  grant_cycles;

  assign done_vld = (state_q == COUNT) && (cnt_q == '0);
  assign acc_ok   = (state_q == IDLE) || (done_vld && done_rdy);
  assign busy     = (state_q == COUNT);
  assign done_id  = done_vld ? cur_id_q : '0;

  // Scan from rr_ptr upward (mod NUM_REQ); the first valid requester wins.
  // NOTE: every variable gets a default at the top of an always_comb; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    req_rdy     = '0;
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (acc_ok && !grant_found && req_vld[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
    if (grant_found) req_rdy[grant_id] = 1'b1;
  end

  assign grant_cycles = req_cycles[int'(grant_id)*CNT_W +: CNT_W];

  // A zero request loads the same terminal count as a request of one.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_id_d = cur_id_q;
    rr_ptr_d = rr_ptr_q;
    if (grant_found) begin
      state_d  = COUNT;
      cnt_d    = (grant_cycles == '0) ? '0 : grant_cycles - CNT_W'(1);
      cur_id_d = grant_id;
      rr_ptr_d = ID_W'((int'(grant_id) + 1) % NUM_REQ);
    end else if (done_vld && done_rdy) begin
      state_d = IDLE;
    end else if ((state_q == COUNT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cur_id_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cur_id_q <= cur_id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_rr_latency_scheduler.sv
// Directed and random stimulus for rr_latency_scheduler, checked against an
// event-time reference model (done time = accept edge + effective latency).
module tb_rr_latency_scheduler;

  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int IW   = $clog2(N);

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [N*CW-1:0] req_cycles;
  logic [N-1:0]    req_rdy;
  logic            done_vld;
  logic [IW-1:0]   done_id;
  logic            done_rdy;
  logic            busy;

  rr_latency_scheduler #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_cycles(req_cycles),
    .req_rdy   (req_rdy),
    .done_vld  (done_vld),
    .done_id   (done_id),
    .done_rdy  (done_rdy),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: job held as (owner, edge count at which done becomes visible).
  int edge_n;
  bit m_busy;
  int m_id;
  int m_done_at;
  int m_ptr;

  // Edges (posedge numbers) at which the DUT completed handshakes.
  int acc_e[$];
  int acc_id[$];
  int done_e[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cyc(input int i, input int c);
    req_cycles[i*CW +: CW] = CW'(c);
  endtask

  task automatic clear_log();
    acc_e.delete();
    acc_id.delete();
    done_e.delete();
  endtask

  // Compare one cycle's outputs against the model, then advance one edge.
  task automatic tick();
    logic [N-1:0] exp_rdy;
    bit           exp_done;
    bit           acc;
    int           g;
    int           lat;
    #1;
    exp_done = m_busy && (edge_n >= m_done_at);
    acc      = !m_busy || (exp_done && done_rdy);
    exp_rdy  = '0;
    g        = -1;
    if (acc) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_rdy",  32'(req_rdy),  32'(exp_rdy));
    check("done_vld", 32'(done_vld), 32'(exp_done));
    check("done_id",  32'(done_id),  exp_done ? 32'(m_id) : 32'd0);
    check("busy",     32'(busy),     32'(m_busy));
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          acc_e.push_back(edge_n + 1);
          acc_id.push_back(i);
        end
      end
      if (done_vld && done_rdy) done_e.push_back(edge_n + 1);
    end
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 0;
    end else if (g >= 0) begin
      lat       = int'(req_cycles[g*CW +: CW]);
      if (lat == 0) lat = 1;
      m_busy    = 1'b1;
      m_id      = g;
      m_done_at = edge_n + lat;
      m_ptr     = (g + 1) % N;
    end else if (exp_done && done_rdy) begin
      m_busy = 1'b0;
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic drain();
    req_vld  = '0;
    done_rdy = 1'b1;
    for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; req_vld = '0; req_cycles = '0; done_rdy = 1'b1;
    checks = 0; errors = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    edge_n = 0; m_busy = 1'b0; m_id = 0; m_done_at = 0; m_ptr = 0;

    // Reset state with requests idle.
    tick();
    rst = 1'b0;
    tick();

    // Single request, L=3.
    clear_log();
    req_vld = 4'b0001; set_cyc(0, 3);
    tick();
    req_vld = '0;
    repeat (4) tick();
    check("t1_done_cnt", 32'(done_e.size()), 32'd1);
    if (done_e.size() == 1 && acc_e.size() == 1)
      check("t1_latency", 32'(done_e[0] - acc_e[0]), 32'd3);

    // Zero then one latency from requester 2, back to back.
    clear_log();
    req_vld = 4'b0100; set_cyc(2, 0);
    tick();
    set_cyc(2, 1);
    tick();
    req_vld = '0;
    repeat (2) tick();
    check("t2_acc_cnt", 32'(acc_e.size()), 32'd2);
    check("t2_done_cnt", 32'(done_e.size()), 32'd2);
    if (acc_e.size() == 2 && done_e.size() == 2) begin
      check("t2_lat0", 32'(done_e[0] - acc_e[0]), 32'd1);
      check("t2_lat1", 32'(done_e[1] - acc_e[1]), 32'd1);
      check("t2_no_bubble", 32'(acc_e[1]), 32'(done_e[0]));
    end

    // Round-robin fairness from a fresh pointer.
    rst = 1'b1; tick(); rst = 1'b0;
    clear_log();
    for (int i = 0; i < N; i++) set_cyc(i, 2);
    req_vld = 4'b1111;
    repeat (10) tick();
    check("t3_acc_cnt_min", 32'(acc_id.size() >= 5), 32'd1);
    if (acc_id.size() >= 5) begin
      check("t3_g0", 32'(acc_id[0]), 32'd0);
      check("t3_g1", 32'(acc_id[1]), 32'd1);
      check("t3_g2", 32'(acc_id[2]), 32'd2);
      check("t3_g3", 32'(acc_id[3]), 32'd3);
      check("t3_g4", 32'(acc_id[4]), 32'd0);
    end
    if (done_e.size() >= 3) begin
      check("t3_gap01", 32'(done_e[1] - done_e[0]), 32'd2);
      check("t3_gap12", 32'(done_e[2] - done_e[1]), 32'd2);
    end else check("t3_done_cnt", 32'(done_e.size()), 32'd3);
    drain();

    // Backpressure: requester 1 done held while requester 3 waits.
    clear_log();
    req_vld = 4'b0010; set_cyc(1, 2);
    tick();
    req_vld = 4'b1000; set_cyc(3, 3);
    tick();
    done_rdy = 1'b0;
    repeat (3) tick();
    done_rdy = 1'b1;
    tick();
    req_vld = '0;
    check("t4_acc_cnt", 32'(acc_id.size()), 32'd2);
    check("t4_done_cnt", 32'(done_e.size()), 32'd1);
    if (acc_id.size() == 2 && done_e.size() == 1) begin
      check("t4_second_id", 32'(acc_id[1]), 32'd3);
      check("t4_grant_on_done", 32'(acc_e[1]), 32'(done_e[0]));
      check("t4_held_latency", 32'(done_e[0] - acc_e[0]), 32'd5);
    end
    drain();

    // Reset mid-job drops the job and returns the pointer to 0.
    clear_log();
    req_vld = 4'b0010; set_cyc(1, 5);
    tick();
    req_vld = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    req_vld = 4'b1100;
    tick();
    req_vld = '0;
    check("t5_no_done", 32'(done_e.size()), 32'd0);
    if (acc_id.size() == 2) check("t5_regrant_id", 32'(acc_id[1]), 32'd2);
    else check("t5_acc_cnt", 32'(acc_id.size()), 32'd2);
    drain();

    // Maximum requested count.
    clear_log();
    req_vld = 4'b0001; set_cyc(0, 255);
    tick();
    req_vld = '0;
    for (int i = 0; i < 300 && done_e.size() == 0; i++) tick();
    check("t6_done_cnt", 32'(done_e.size()), 32'd1);
    if (done_e.size() == 1 && acc_e.size() == 1)
      check("t6_latency", 32'(done_e[0] - acc_e[0]), 32'd255);
    drain();

    // Random traffic with backpressure and occasional reset.
    for (int c = 0; c < 400; c++) begin
      req_vld  = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) set_cyc(i, int'($urandom_range(0, 6)));
      done_rdy = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
